// File: rtl/result_serializer.sv
// Result serializer: pops wide result vectors from the result FIFO
// and streams them to the host tx FIFO as framed narrow words.
module result_serializer #(
  parameter int IN_W  = 512,
  parameter int OUT_W = 128,
  parameter int SWAP  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_empty,
  output logic             in_rdreq,
  input  logic [IN_W-1:0]  in_q,
  input  logic             in_last,
  input  logic             out_full,
  output logic             out_wrreq,
  output logic [OUT_W-1:0] out_d,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int IW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);

  // State names the cycle in which the registered outputs are visible:
  // REQ  - in_rdreq is high (possibly alongside the final write),
  // LOAD - in_q carries the requested vector,
  // EMIT - a slice of the held vector is written or paused.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_n;
  logic [IW-1:0]     cur_idx;
  logic [IN_W-1:0]   hold;
  logic              hold_last;
  logic [IN_W-1:0]   src;
  logic              src_last;
  logic              rdreq_n;
  logic              wrreq_n;
  logic [OUT_W-1:0]  d_n;
  logic              last_n;
  logic              busy_n;

  function automatic logic [OUT_W-1:0] slice(
    input logic [IN_W-1:0] v,
    input logic [IW-1:0]   i
  );
    int s;
    s = (SWAP != 0) ? (RATIO - 1 - int'(i)) : int'(i);
    return v[s*OUT_W +: OUT_W];
  endfunction

  // The first slice is taken straight from in_q while it is being
  // captured, so the first write lands one cycle after LOAD.
  assign src      = (state == LOAD) ? in_q : hold;
  assign src_last = (state == LOAD) ? in_last : hold_last;
  assign cur_idx  = (state == LOAD) ? '0 : idx;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and next-output decode; clear overrides everything.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    rdreq_n = 1'b0;
    wrreq_n = 1'b0;
    d_n     = out_d;
    last_n  = 1'b0;
    if (clear) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!in_empty) begin
            state_n = REQ;
            rdreq_n = 1'b1;
          end
        end
        REQ: begin
          state_n = LOAD;
        end
        LOAD, EMIT: begin
          state_n = EMIT;
          idx_n   = cur_idx;
          // out_full is an almost-full flag, so acting on the value
          // sampled at this edge leaves the tx FIFO room for one word.
          if (!out_full) begin
            wrreq_n = 1'b1;
            d_n     = slice(src, cur_idx);
            last_n  = src_last & (cur_idx == LAST_IDX);
            if (cur_idx == LAST_IDX) begin
              idx_n = '0;
              if (!in_empty) begin
                state_n = REQ;
                rdreq_n = 1'b1;
              end else begin
                state_n = IDLE;
              end
            end else begin
              idx_n = cur_idx + 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          idx_n   = '0;
        end
      endcase
    end
    busy_n = (state_n != IDLE) | wrreq_n;
  end

  // Slice index and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      in_rdreq  <= 1'b0;
      out_wrreq <= 1'b0;
      out_d     <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      idx       <= idx_n;
      in_rdreq  <= rdreq_n;
      out_wrreq <= wrreq_n;
      out_d     <= d_n;
      out_last  <= last_n;
      busy      <= busy_n;
    end
  end

  // Holding register: captures the vector returned by the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      hold_last <= 1'b0;
    end else if (state == LOAD && !clear) begin
      hold      <= in_q;
      hold_last <= in_last;
    end
  end

  // Performance counters; they survive clear and wrap silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_sent  <= '0;
      frames_sent <= '0;
    end else begin
      if (out_wrreq) begin
        words_sent <= words_sent + CNT_W'(1);
      end
      if (out_last) begin
        frames_sent <= frames_sent + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: two instances (MS-first and
// LS-first) share one FIFO model and directed stimulus.
module tb_result_serializer;

  localparam logic [511:0] JUNK = {16{32'hdeadbeef}};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic         in_empty = 1'b1;
  logic [511:0] in_q = '0;
  logic         in_last = 1'b0;
  logic         out_full = 1'b0;

  logic         rd1, w1, l1, b1;
  logic [127:0] d1;
  logic [31:0]  ws1, fs1;
  logic         rd0, w0, l0, b0;
  logic [127:0] d0;
  logic [31:0]  ws0, fs0;

  int n_vec = 0;
  int n_err = 0;

  logic [128:0] q1[$];
  logic [128:0] q0[$];

  logic [512:0] fmem [0:15];
  int           wp = 0;
  int           rp = 0;
  logic         pend = 1'b0;
  logic [512:0] pend_e = '0;

  always #5 clk = ~clk;

  result_serializer #(.IN_W(512), .OUT_W(128), .SWAP(1), .CNT_W(32)) u1 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_empty(in_empty), .in_rdreq(rd1), .in_q(in_q), .in_last(in_last),
    .out_full(out_full), .out_wrreq(w1), .out_d(d1), .out_last(l1),
    .busy(b1), .words_sent(ws1), .frames_sent(fs1)
  );

  result_serializer #(.IN_W(512), .OUT_W(128), .SWAP(0), .CNT_W(32)) u0 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_empty(in_empty), .in_rdreq(rd0), .in_q(in_q), .in_last(in_last),
    .out_full(out_full), .out_wrreq(w0), .out_d(d0), .out_last(l0),
    .busy(b0), .words_sent(ws0), .frames_sent(fs0)
  );

  // FIFO model: request seen in cycle c, data presented in cycle c+1 only.
  always @(negedge clk) begin
    if (rd1 && rp != wp) begin
      pend_e = fmem[rp % 16];
      rp = rp + 1;
      pend = 1'b1;
    end else begin
      pend = 1'b0;
    end
    in_empty = (rp == wp);
  end

  always @(posedge clk) begin
    if (pend) begin
      in_q    <= pend_e[511:0];
      in_last <= pend_e[512];
    end else begin
      in_q    <= JUNK;
      in_last <= 1'b0;
    end
  end

  // Monitor: every write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    logic [128:0] e;
    if (!reset && w1) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL swap1_word: unexpected write last=%0b d=%0h", l1, d1);
      end else begin
        e = q1.pop_front();
        if ({l1, d1} !== e) begin
          n_err++;
          $display("FAIL swap1_word: got last=%0b d=%0h, expected last=%0b d=%0h",
                   l1, d1, e[128], e[127:0]);
        end
      end
    end
    if (!reset && w0) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL swap0_word: unexpected write last=%0b d=%0h", l0, d0);
      end else begin
        e = q0.pop_front();
        if ({l0, d0} !== e) begin
          n_err++;
          $display("FAIL swap0_word: got last=%0b d=%0h, expected last=%0b d=%0h",
                   l0, d0, e[128], e[127:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue a vector in the FIFO model and the first nw expected words.
  task automatic send(input logic [511:0] v, input logic last, input int nw);
    @(posedge clk);
    #1;
    fmem[wp % 16] = {last, v};
    wp = wp + 1;
    for (int i = 0; i < nw; i++) begin
      q1.push_back({last && (i == 3), v[(3-i)*128 +: 128]});
      q0.push_back({last && (i == 3), v[i*128 +: 128]});
    end
  endtask

  task automatic expect_pat(input string nm, input logic [15:0] wpat,
                            input logic [15:0] rpat, input int n);
    logic [15:0] wg;
    logic [15:0] rg;
    wg = '0;
    rg = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wg[i] = w1;
      rg[i] = rd1;
    end
    chk({nm, "_wrreq"}, 128'(wg), 128'(wpat));
    chk({nm, "_rdreq"}, 128'(rg), 128'(rpat));
  endtask

  task automatic wait_done(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (q1.size() == 0 && q0.size() == 0 && !b1 && !b0) ok = 1'b1;
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_done: timeout, pending %0d/%0d words", nm, q1.size(), q0.size());
    end
  endtask

  task automatic wait_writes(input string nm, input int k);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40 && cnt < k; i++) begin
      @(negedge clk);
      if (w1) cnt++;
    end
    n_vec++;
    if (cnt < k) begin
      n_err++;
      $display("FAIL %s_writes: saw %0d, required %0d", nm, cnt, k);
    end
  endtask

  initial begin
    logic [511:0] v;
    logic         nowr;
    #12;
    chk("reset_outputs", {w1, rd1, b1, l1, w0, rd0, b0, l0}, '0);
    chk("reset_data", d1 | d0, '0);
    chk("reset_counters", {ws1, fs1, ws0, fs0}, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single framed vector: 3-cycle latency then 4 consecutive words.
    v = {128'h4, 128'h3, 128'h2, 128'h1};
    send(v, 1'b1, 4);
    expect_pat("single", 16'h0078, 16'h0002, 8);
    wait_done("single");
    chk("single_words", ws1, 32'd4);
    chk("single_frames", fs1, 32'd1);
    chk("single_words0", ws0, 32'd4);
    chk("single_frames0", fs0, 32'd1);

    // Back-to-back vectors, only B is a frame end.
    v = {128'ha3, 128'ha2, 128'ha1, 128'ha0};
    send(v, 1'b0, 4);
    v = {128'hb3b3, 128'hb2b2, 128'hb1b1, 128'hb0b0};
    fmem[wp % 16] = {1'b1, v};
    wp = wp + 1;
    for (int i = 0; i < 4; i++) begin
      q1.push_back({i == 3, v[(3-i)*128 +: 128]});
      q0.push_back({i == 3, v[i*128 +: 128]});
    end
    expect_pat("b2b", 16'h0F78, 16'h0042, 13);
    wait_done("b2b");
    chk("b2b_words", ws1, 32'd12);
    chk("b2b_frames", fs1, 32'd2);

    // Backpressure for 5 cycles after the second word.
    v = {128'hc3 << 100, 128'hc2 << 64, 128'hc1 << 32, 128'hc0};
    send(v, 1'b1, 4);
    wait_writes("full", 2);
    out_full = 1'b1;
    nowr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      nowr = nowr | w1 | w0;
    end
    out_full = 1'b0;
    chk("full_hold_nowrite", 128'(nowr), '0);
    wait_done("full");
    chk("full_words", ws1, 32'd16);
    chk("full_frames", fs1, 32'd3);

    // Clear after the second word drops the rest of the vector.
    v = {128'hd3, 128'hd2, 128'hd1, 128'hd0};
    send(v, 1'b1, 2);
    wait_writes("clear", 2);
    clear = 1'b1;
    @(negedge clk);
    chk("clear_busy", {b1, b0, w1, w0}, '0);
    clear = 1'b0;
    nowr = 1'b0;
    repeat (6) begin
      @(negedge clk);
      nowr = nowr | w1 | w0;
    end
    chk("clear_nowrite", 128'(nowr), '0);
    chk("clear_words", ws1, 32'd18);
    chk("clear_frames", fs1, 32'd3);
    v = {128'he3, 128'he2, 128'he1, 128'he0};
    send(v, 1'b1, 4);
    wait_done("after_clear");
    chk("after_clear_words", ws1, 32'd22);
    chk("after_clear_frames", fs1, 32'd4);

    // Asynchronous reset in the middle of a vector.
    v = {128'hf3, 128'hf2, 128'hf1, 128'hf0};
    send(v, 1'b1, 1);
    wait_writes("reset", 1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_reset_outputs", {w1, rd1, b1, l1, w0, rd0, b0, l0}, '0);
    chk("mid_reset_data", d1 | d0, '0);
    chk("mid_reset_counters", {ws1, fs1, ws0, fs0}, '0);
    q1.delete();
    q0.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", {b1, rd1, w1}, '0);
    v = {128'h1234, 128'h5678, 128'h9abc, 128'hdef0};
    send(v, 1'b1, 4);
    wait_done("after_reset");
    chk("after_reset_words", ws1, 32'd4);
    chk("after_reset_frames", fs1, 32'd1);
    chk("after_reset_words0", ws0, 32'd4);

    chk("leftover", 128'(q1.size() + q0.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
